// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over raster-ordered pixels, all channels in parallel.
// Define POOL_RELU_EN to fuse a ReLU clamp into the output register stage.
module maxpool2x2_stream #(
  parameter int N          = 16,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] pool_dout,
  output logic                 pool_dout_vld,
  output logic                 pool_dout_end
);

  localparam int DEPTH = INPUT_SIZE / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic [CHANNEL*N-1:0] r_hreg;
  logic [CHANNEL*N-1:0] r_linebuf [DEPTH];

  logic [AW-1:0]        w_lbIdx;
  logic [CHANNEL*N-1:0] w_hmax;
  logic [CHANNEL*N-1:0] w_pool;
  logic                 w_lastPix;
  logic                 w_firstPix;

  assign w_lbIdx    = r_col[CW-1:1];
  assign w_lastPix  = (r_row == LAST) && (r_col == LAST);
  assign w_firstPix = (r_row == '0) && (r_col == '0);

  for (genvar g = 0; g < CHANNEL; g++) begin : g_ch
    logic signed [N-1:0] w_in;
    logic signed [N-1:0] w_h;
    logic signed [N-1:0] w_lb;
    logic signed [N-1:0] w_hm;
    logic signed [N-1:0] w_vm;

    assign w_in = input_din[g*N +: N];
    assign w_h  = r_hreg[g*N +: N];
    assign w_lb = r_linebuf[w_lbIdx][g*N +: N];
    assign w_hm = (w_in > w_h) ? w_in : w_h;
    assign w_vm = (w_hm > w_lb) ? w_hm : w_lb;
    assign w_hmax[g*N +: N] = w_hm;
`ifdef POOL_RELU_EN
    assign w_pool[g*N +: N] = w_vm[N-1] ? '0 : w_vm;
`else
    assign w_pool[g*N +: N] = w_vm;
`endif
  end

  // Line buffer holds the top-row horizontal maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (input_vld && r_col[0] && !r_row[0]) begin
      r_linebuf[w_lbIdx] <= w_hmax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_hreg        <= '0;
      pool_dout     <= '0;
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b1;
    end else begin
      pool_dout_vld <= 1'b0;
      if (input_vld) begin
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (!r_col[0]) begin
          r_hreg <= input_din;
        end
        if (w_firstPix) begin
          pool_dout_end <= 1'b0;
        end
        // Bottom-right pixel of a window completes the 2x2 max.
        if (r_col[0] && r_row[0]) begin
          pool_dout     <= w_pool;
          pool_dout_vld <= 1'b1;
          if (w_lastPix) begin
            pool_dout_end <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream at N=16, CHANNEL=2, INPUT_SIZE=4.
// Expected pooled pixels come from hand-computed tables pushed as each window completes.
module tb_maxpool2x2_stream;

  localparam int N  = 16;
  localparam int CH = 2;
  localparam int SZ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            input_vld = 1'b0;
  logic [CH*N-1:0] input_din = '0;
  logic [CH*N-1:0] pool_dout;
  logic            pool_dout_vld;
  logic            pool_dout_end;

  typedef struct {
    logic [CH*N-1:0] data;
    logic            endFlag;
    int              cycle;
  } exp_t;

  exp_t       sb[$];
  exp_t       monE;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [N-1:0] exp0 [4];
  logic [N-1:0] exp1 [4];

  maxpool2x2_stream #(.N(N), .CHANNEL(CH), .INPUT_SIZE(SZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_vld    (input_vld),
    .input_din    (input_din),
    .pool_dout    (pool_dout),
    .pool_dout_vld(pool_dout_vld),
    .pool_dout_end(pool_dout_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding window, including its cycle.
  always @(negedge clk) begin
    if (pool_dout_vld === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_vld: got pulse with data %0h, required none", pool_dout);
      end else begin
        monE = sb.pop_front();
        checkOutput("pool_dout", 64'(pool_dout), 64'(monE.data));
        checkOutput("pool_dout_end", 64'(pool_dout_end), 64'(monE.endFlag));
        checkOutput("vld_cycle", 64'(cyc), 64'(monE.cycle));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      input_vld = 1'b0;
    end
  endtask

  // mode 0: ramp+offset, mode 1: negatives, mode 2: extreme-value window on ch0
  task automatic applyStimulus(input int mode, input int offset, input bit gap, input int nPix);
    logic [N-1:0] c0;
    logic [N-1:0] c1;
    int row;
    int col;
    int k;
    for (int p = 0; p < nPix; p++) begin
      if (gap && p > 0) begin
        @(negedge clk);
        input_vld = 1'b0;
      end
      @(negedge clk);
      if (p == 1) checkOutput("end_fall", 64'(pool_dout_end), 64'd0);
      case (mode)
        0: begin c0 = N'(p + offset); c1 = N'(p + offset); end
        1: begin c0 = N'(-(p + 1));   c1 = N'(p - 8);      end
        default: begin
          c1 = N'(p);
          case (p)
            0: c0 = 16'h7FFF;
            1: c0 = 16'h8000;
            5: c0 = 16'h0001;
            default: c0 = 16'h0000;
          endcase
        end
      endcase
      input_vld = 1'b1;
      input_din = {c1, c0};
      row = p / SZ;
      col = p % SZ;
      if ((row % 2 == 1) && (col % 2 == 1)) begin
        k = (row / 2) * 2 + col / 2;
        sb.push_back('{data: {exp1[k], exp0[k]}, endFlag: (k == 3), cycle: cyc + 1});
      end
    end
  endtask

  task automatic setRamp(input int offset);
    exp0 = '{N'(5 + offset), N'(7 + offset), N'(13 + offset), N'(15 + offset)};
    exp1 = exp0;
  endtask

  initial begin
    int waitCnt;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_dout", 64'(pool_dout), 64'd0);
    checkOutput("reset_vld", 64'(pool_dout_vld), 64'd0);
    checkOutput("reset_end", 64'(pool_dout_end), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] T1 ramp");
    setRamp(0);
    applyStimulus(0, 0, 1'b0, 16);
    idle(3);
    checkOutput("t1_end_idle", 64'(pool_dout_end), 64'd1);

    $display("[TB] T2 negatives");
`ifdef POOL_RELU_EN
    exp0 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp1 = '{16'h0000, 16'h0000, 16'h0005, 16'h0007};
`else
    exp0 = '{16'hFFFF, 16'hFFFD, 16'hFFF7, 16'hFFF5};
    exp1 = '{16'hFFFD, 16'hFFFF, 16'h0005, 16'h0007};
`endif
    applyStimulus(1, 0, 1'b0, 16);
    idle(3);

    $display("[TB] T3 bubbles");
    setRamp(0);
    applyStimulus(0, 0, 1'b1, 16);
    idle(3);

    $display("[TB] T4 back-to-back");
    setRamp(0);
    applyStimulus(0, 0, 1'b0, 16);
    setRamp(100);
    applyStimulus(0, 100, 1'b0, 16);
    idle(3);

    $display("[TB] T5 reset mid-frame");
    setRamp(0);
    applyStimulus(0, 0, 1'b0, 10);
    @(negedge clk);
    input_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_dout", 64'(pool_dout), 64'd0);
    checkOutput("t5_rst_vld", 64'(pool_dout_vld), 64'd0);
    checkOutput("t5_rst_end", 64'(pool_dout_end), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1'b0, 16);
    idle(3);

    $display("[TB] T6 extremes");
    exp0 = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    exp1 = '{16'd5, 16'd7, 16'd13, 16'd15};
    applyStimulus(2, 0, 1'b0, 16);
    idle(3);

    waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors += sb.size();
      $display("[TB] FAIL drain: got %0d outstanding outputs, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
